// File: rtl/sample_ram_responder.sv
// On-chip word RAM behind a read/write/waitrequest/valid port with programmable wait states.
// Define RAM_CLEAR_EN to zero the array after every reset.
module sample_ram_responder #(
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [21:0] ram_addr,
  input  logic [15:0] ram_data_in,
  input  logic        ram_read,
  input  logic        ram_write,
  output logic [15:0] ram_data_out,
  output logic        ram_valid,
  output logic        ram_waitrq
);

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

`ifdef RAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACK, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  logic [15:0] mem [DEPTH];

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic           wrq_q, wrq_d;
  logic           vld_q, vld_d;
  logic [15:0]    dout_q;
  logic           mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [15:0]    mem_wd;
  logic [ADDR_BITS-1:0] idx;
  logic           req;
  logic           unused_hi;

`ifdef RAM_CLEAR_EN
  logic [ADDR_BITS-1:0] clr_q, clr_d;
`endif

  assign idx       = ram_addr[ADDR_BITS-1:0];
  assign req       = ram_read | ram_write;
  assign unused_hi = ^ram_addr[21:ADDR_BITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    mem_we  = 1'b0;
    mem_wa  = idx;
    mem_wd  = ram_data_in;
`ifdef RAM_CLEAR_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = WC;
          wr_d    = ram_write;
          state_d = (WC == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        // initiator abandoned the command: drop it without touching the array
        if (!req) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          wr_d  = ram_write;
          if (cnt_q == 4'd1) state_d = ACK;
        end
      end
      ACK: begin
        mem_we  = wr_q;
        state_d = IDLE;
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_q;
        mem_wd = 16'h0000;
        clr_d  = clr_q + ADDR_BITS'(1);
        if (&clr_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    wrq_d = (state_d != ACK);
    vld_d = (state_d == ACK) && !wr_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      wrq_q   <= 1'b1;
      vld_q   <= 1'b0;
      dout_q  <= 16'h0000;
`ifdef RAM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wrq_q   <= wrq_d;
      vld_q   <= vld_d;
      if (vld_d) dout_q <= mem[idx];
`ifdef RAM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // a write whose ACK coincides with reset is dropped
  always_ff @(posedge CLOCK_50) begin
    if (mem_we && !reset) mem[mem_wa] <= mem_wd;
  end

  assign ram_data_out = dout_q;
  assign ram_valid    = vld_q;
  assign ram_waitrq   = wrq_q;

endmodule

// File: tb/tb_sample_ram_responder.sv
// Randomized bench for sample_ram_responder against an address-keyed memory model.
// Checks acceptance latency, valid/waitrequest coincidence, aliasing and reset behaviour.
module tb_sample_ram_responder;

  localparam int W = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [21:0] ram_addr;
  logic [15:0] ram_data_in;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] ram_data_out;
  logic        ram_valid;
  logic        ram_waitrq;

  int total = 0;
  int bad   = 0;
  int reads = 0;
  int pulses = 0;
  logic [15:0] model [int];
  logic [15:0] last_rd;

  sample_ram_responder #(.ADDR_BITS(16), .WAIT_CYCLES(W)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_data_out(ram_data_out),
    .ram_valid   (ram_valid),
    .ram_waitrq  (ram_waitrq)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (ram_valid === 1'b1) begin
      pulses++;
      chk("vld_wrq", ram_waitrq, 1'b0);
    end
  end

  // caller sits at a negedge; request appears now, accept expected W+1 cycles later
  task automatic xfer(input logic [21:0] a, input logic [15:0] d,
                      input logic r, input logic w);
    int  n;
    bit  done;
    ram_addr    = a;
    ram_data_in = d;
    ram_read    = r;
    ram_write   = w;
    n    = 0;
    done = 0;
    while (!done && n < 50) begin
      @(negedge CLOCK_50);
      n++;
      if (ram_waitrq === 1'b0) done = 1;
    end
    chk("accept", done, 1);
    chk("latency", n, W + 1);
    if (w) begin
      chk("wr_vld", ram_valid, 1'b0);
      chk("hold", ram_data_out, last_rd);
      model[int'(a[15:0])] = d;
    end else begin
      reads++;
      chk("rd_vld", ram_valid, 1'b1);
      chk("rd_data", ram_data_out, model[int'(a[15:0])]);
      last_rd = model[int'(a[15:0])];
    end
    @(negedge CLOCK_50);
    chk("idle_wrq", ram_waitrq, 1'b1);
    chk("idle_vld", ram_valid, 1'b0);
    ram_read  = 1'b0;
    ram_write = 1'b0;
  endtask

  initial begin
    logic [15:0] pool [8];
    reset       = 1'b1;
    ram_addr    = '0;
    ram_data_in = '0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    last_rd     = 16'h0000;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_wrq", ram_waitrq, 1'b1);
    chk("rst_vld", ram_valid, 1'b0);
    chk("rst_dout", ram_data_out, 16'h0000);
    reset = 1'b0;
    @(negedge CLOCK_50);

    xfer(22'd5, 16'h1234, 1'b0, 1'b1);
    xfer(22'd5, 16'h0000, 1'b1, 1'b0);

    xfer(22'h10005, 16'hBEEF, 1'b0, 1'b1);
    xfer(22'h00005, 16'h0000, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) xfer(22'(k + 16), 16'(k), 1'b0, 1'b1);
    for (int k = 0; k < 8; k += 2) xfer(22'(k + 16), 16'h0, 1'b1, 1'b0);

    // read+write together: write wins, no valid
    xfer(22'd3, 16'h00AA, 1'b1, 1'b1);
    xfer(22'd3, 16'h0000, 1'b1, 1'b0);

    // request withdrawn during wait states
    ram_addr    = 22'd3;
    ram_data_in = 16'h5555;
    ram_write   = 1'b1;
    @(negedge CLOCK_50);
    ram_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      chk("drop_wrq", ram_waitrq, 1'b1);
    end
    xfer(22'd3, 16'h0000, 1'b1, 1'b0);

    // reset during the wait states of a write
    ram_addr    = 22'd5;
    ram_data_in = 16'hDEAD;
    ram_write   = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("mid_rst_wrq", ram_waitrq, 1'b1);
    chk("mid_rst_vld", ram_valid, 1'b0);
    chk("mid_rst_dout", ram_data_out, 16'h0000);
    reset     = 1'b0;
    ram_write = 1'b0;
    last_rd   = 16'h0000;
    @(negedge CLOCK_50);
    chk("post_rst_wrq", ram_waitrq, 1'b1);
    xfer(22'd5, 16'h0000, 1'b1, 1'b0);

    pool[0] = 16'h0000;
    pool[1] = 16'hFFFF;
    for (int i = 2; i < 8; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 150; i++) begin
      logic [21:0] a;
      logic        rd;
      a  = {6'($urandom), pool[$urandom_range(0, 7)]};
      rd = ($urandom_range(0, 1) == 1);
      if (rd && !model.exists(int'(a[15:0]))) rd = 1'b0;
      if (rd) xfer(a, 16'h0, 1'b1, 1'b0);
      else    xfer(a, 16'($urandom), 1'b0, 1'b1);
    end

    @(negedge CLOCK_50);
    chk("pulses", pulses, reads);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
